// File: rtl/dcache_direct_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Sits between the CPU MEM stage and data memory; counts hits and misses.
module dcache_direct_wt #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   readC,
  input  logic                   writeC,
  input  logic [WORD_SIZE-1:0]   addressC,
  input  logic [WORD_SIZE-1:0]   dataC_in,
  output logic [WORD_SIZE-1:0]   dataC_out,
  output logic                   doneC,
  output logic                   readM,
  output logic                   writeM,
  output logic [WORD_SIZE-1:0]   addressM,
  output logic [WORD_SIZE-1:0]   dataM_out,
  input  logic [4*WORD_SIZE-1:0] dataM_in,
  input  logic                   ackM,
  output logic [WORD_SIZE-1:0]   hit_count,
  output logic [WORD_SIZE-1:0]   miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = WORD_SIZE - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e                                 state_q, state_d;
  logic [LINES-1:0]                       valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]            tag_q, tag_d;
  logic [LINES-1:0][3:0][WORD_SIZE-1:0]   data_q, data_d;
  logic [WORD_SIZE-1:0]                   req_q, req_d;
  logic [WORD_SIZE-1:0]                   dout_q, dout_d;
  logic [WORD_SIZE-1:0]                   addrm_q, addrm_d;
  logic [WORD_SIZE-1:0]                   datam_q, datam_d;
  logic [WORD_SIZE-1:0]                   hit_q, hit_d;
  logic [WORD_SIZE-1:0]                   miss_q, miss_d;

  logic [INDEX_BITS-1:0] c_idx, f_idx;
  logic [TAG_W-1:0]      c_tag, f_tag;
  logic [1:0]            c_off, f_off;
  logic                  c_hit;

  assign c_off = addressC[1:0];
  assign c_idx = addressC[INDEX_BITS+1:2];
  assign c_tag = addressC[WORD_SIZE-1:INDEX_BITS+2];
  assign f_off = req_q[1:0];
  assign f_idx = req_q[INDEX_BITS+1:2];
  assign f_tag = req_q[WORD_SIZE-1:INDEX_BITS+2];
  assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    req_d   = req_q;
    dout_d  = dout_q;
    addrm_d = addrm_q;
    datam_d = datam_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (writeC) begin
          addrm_d = addressC;
          datam_d = dataC_in;
          state_d = WRITE;
          if (c_hit) begin
            data_d[c_idx][c_off] = dataC_in;
            if (hit_q != '1) hit_d = hit_q + WORD_SIZE'(1);
          end else if (miss_q != '1) begin
            miss_d = miss_q + WORD_SIZE'(1);
          end
        end else if (readC) begin
          if (c_hit) begin
            dout_d  = data_q[c_idx][c_off];
            state_d = DONE;
            if (hit_q != '1) hit_d = hit_q + WORD_SIZE'(1);
          end else begin
            req_d   = addressC;
            addrm_d = {addressC[WORD_SIZE-1:2], 2'b00};
            state_d = FILL;
            if (miss_q != '1) miss_d = miss_q + WORD_SIZE'(1);
          end
        end
      end
      FILL: begin
        if (ackM) begin
          data_d[f_idx]  = dataM_in;
          tag_d[f_idx]   = f_tag;
          valid_d[f_idx] = 1'b1;
          dout_d         = dataM_in[f_off*WORD_SIZE +: WORD_SIZE];
          state_d        = DONE;
        end
      end
      WRITE: if (ackM) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      req_q   <= '0;
      dout_q  <= '0;
      addrm_q <= '0;
      datam_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      addrm_q <= addrm_d;
      datam_q <= datam_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Handshake strobes are pure state decodes, so a reset drops them immediately.
  assign readM      = (state_q == FILL);
  assign writeM     = (state_q == WRITE);
  assign doneC      = (state_q == DONE);
  assign dataC_out  = dout_q;
  assign addressM   = addrm_q;
  assign dataM_out  = datam_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_dcache_direct_wt.sv
// Randomised self-checking bench: the bench plays CPU and memory and predicts
// results from a word-level memory image plus a per-index resident-line table.
module tb_dcache_direct_wt;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        readC = 1'b0, writeC = 1'b0;
  logic [15:0] addressC = '0, dataC_in = '0;
  logic [15:0] dataC_out, addressM, dataM_out, hit_count, miss_count;
  logic        doneC, readM, writeM;
  logic [63:0] dataM_in = '0;
  logic        ackM = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory contents, which line each index holds, counters.
  logic [15:0] mem [logic [15:0]];
  bit          m_valid [8];
  logic [13:0] m_line  [8];
  int          exp_hit = 0, exp_miss = 0;

  dcache_direct_wt #(.WORD_SIZE(16), .INDEX_BITS(3)) dut (
    .Clk(Clk), .Reset(Reset), .readC(readC), .writeC(writeC),
    .addressC(addressC), .dataC_in(dataC_in), .dataC_out(dataC_out),
    .doneC(doneC), .readM(readM), .writeM(writeM), .addressM(addressM),
    .dataM_out(dataM_out), .dataM_in(dataM_in), .ackM(ackM),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5C3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; readC = 1'b0; writeC = 1'b0; ackM = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  // One CPU transaction with the bench acting as memory; dly = idle cycles before ack.
  task automatic cpu_access(input bit rd, input bit wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input int dly);
    bit          is_rd, hit;
    logic [2:0]  idx;
    logic [13:0] line;
    is_rd = rd && !wr;
    idx   = addr[4:2];
    line  = addr[15:2];
    hit   = m_valid[idx] && (m_line[idx] == line);
    @(negedge Clk);
    readC = rd; writeC = wr; addressC = addr; dataC_in = wdata;
    if (hit) exp_hit++; else exp_miss++;
    @(negedge Clk);
    if (is_rd && hit) begin
      n_checks++;
      if (doneC !== 1'b1 || readM !== 1'b0 || dataC_out !== mem_rd(addr)) begin
        n_fail++;
        $display("FAIL read_hit @%h: done=%b readM=%b data=%h expected done=1 readM=0 data=%h",
                 addr, doneC, readM, dataC_out, mem_rd(addr));
      end
    end else begin
      n_checks++;
      if (is_rd) begin
        if (readM !== 1'b1 || writeM !== 1'b0 || addressM !== {line, 2'b00}) begin
          n_fail++;
          $display("FAIL fill_req @%h: readM=%b writeM=%b addressM=%h expected 1 0 %h",
                   addr, readM, writeM, addressM, {line, 2'b00});
        end
      end else begin
        if (writeM !== 1'b1 || readM !== 1'b0 || addressM !== addr || dataM_out !== wdata) begin
          n_fail++;
          $display("FAIL write_req @%h: writeM=%b readM=%b addressM=%h dataM_out=%h expected 1 0 %h %h",
                   addr, writeM, readM, addressM, dataM_out, addr, wdata);
        end
      end
      for (int k = 0; k < dly; k++) begin
        @(negedge Clk);
        n_checks++;
        if (doneC !== 1'b0 || (is_rd ? readM : writeM) !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_req @%h: done=%b readM=%b writeM=%b expected strobe held, done=0",
                   addr, doneC, readM, writeM);
        end
      end
      for (int k = 0; k < 4; k++) dataM_in[16*k +: 16] = mem_rd({line, 2'(k)});
      ackM = 1'b1;
      @(negedge Clk);
      ackM = 1'b0;
      if (!is_rd) mem[addr] = wdata;
      else begin
        m_valid[idx] = 1'b1;
        m_line[idx]  = line;
      end
      n_checks++;
      if (doneC !== 1'b1 || readM !== 1'b0 || writeM !== 1'b0 ||
          (is_rd && dataC_out !== mem_rd(addr))) begin
        n_fail++;
        $display("FAIL complete @%h: done=%b readM=%b writeM=%b data=%h expected 1 0 0 data=%h",
                 addr, doneC, readM, writeM, dataC_out, mem_rd(addr));
      end
    end
    readC = 1'b0; writeC = 1'b0;
    n_checks++;
    if (hit_count !== 16'(exp_hit) || miss_count !== 16'(exp_miss)) begin
      n_fail++;
      $display("FAIL counters @%h: hit=%0d miss=%0d expected %0d %0d",
               addr, hit_count, miss_count, exp_hit, exp_miss);
    end
    @(negedge Clk);
    n_checks++;
    if (doneC !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse @%h: done=%b expected 0", addr, doneC);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({doneC, readM, writeM} !== 3'b000 || dataC_out !== 16'h0 || addressM !== 16'h0 ||
        dataM_out !== 16'h0 || hit_count !== 16'h0 || miss_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: done=%b rM=%b wM=%b dout=%h aM=%h dM=%h hit=%h miss=%h expected all 0",
               doneC, readM, writeM, dataC_out, addressM, dataM_out, hit_count, miss_count);
    end
  endtask

  task automatic test_read_miss();
    cpu_access(1, 0, 16'h0005, 16'h0, 2);
    n_checks++;
    if (dataC_out !== 16'hBBBB) begin
      n_fail++;
      $display("FAIL read_miss_value: got %h expected bbbb", dataC_out);
    end
  endtask

  task automatic test_read_hit();
    cpu_access(1, 0, 16'h0006, 16'h0, 0);
    n_checks++;
    if (dataC_out !== 16'hCCCC) begin
      n_fail++;
      $display("FAIL read_hit_value: got %h expected cccc", dataC_out);
    end
  endtask

  task automatic test_write_hit();
    cpu_access(0, 1, 16'h0007, 16'h1234, 1);
    cpu_access(1, 0, 16'h0007, 16'h0, 0);
    n_checks++;
    if (dataC_out !== 16'h1234 || hit_count !== 16'd3) begin
      n_fail++;
      $display("FAIL write_hit: data=%h hit=%0d expected 1234 3", dataC_out, hit_count);
    end
  endtask

  task automatic test_write_miss();
    cpu_access(0, 1, 16'h0100, 16'hBEEF, 0);
    cpu_access(1, 0, 16'h0100, 16'h0, 1);
    n_checks++;
    if (dataC_out !== 16'hBEEF || miss_count !== 16'd3) begin
      n_fail++;
      $display("FAIL write_miss: data=%h miss=%0d expected beef 3", dataC_out, miss_count);
    end
  endtask

  task automatic test_conflict();
    cpu_access(1, 0, 16'h0024, 16'h0, 1);
    cpu_access(1, 0, 16'h0005, 16'h0, 2);
    n_checks++;
    if (miss_count !== 16'd5 || dataC_out !== 16'hBBBB) begin
      n_fail++;
      $display("FAIL conflict: miss=%0d data=%h expected 5 bbbb", miss_count, dataC_out);
    end
  endtask

  task automatic test_priority();
    cpu_access(1, 1, 16'h0006, 16'h7777, 0);
    cpu_access(1, 0, 16'h0006, 16'h0, 0);
  endtask

  task automatic test_idle_ack();
    @(negedge Clk);
    ackM = 1'b1;
    @(negedge Clk);
    ackM = 1'b0;
    n_checks++;
    if ({doneC, readM, writeM} !== 3'b000 || hit_count !== 16'(exp_hit) ||
        miss_count !== 16'(exp_miss)) begin
      n_fail++;
      $display("FAIL idle_ack: done=%b rM=%b wM=%b hit=%0d miss=%0d expected 0 0 0 %0d %0d",
               doneC, readM, writeM, hit_count, miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_reset_during_fill();
    apply_reset();
    @(negedge Clk);
    readC = 1'b1; addressC = 16'h0005;
    @(negedge Clk);
    n_checks++;
    if (readM !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fill_req: readM=%b expected 1", readM);
    end
    Reset = 1'b1; readC = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    n_checks++;
    if (readM !== 1'b0 || doneC !== 1'b0 || miss_count !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_fill_drop: readM=%b done=%b miss=%0d expected 0 0 0",
               readM, doneC, miss_count);
    end
    ackM = 1'b1;
    @(negedge Clk);
    ackM = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (doneC !== 1'b0 || readM !== 1'b0) begin
        n_fail++;
        $display("FAIL late_ack: done=%b readM=%b expected 0 0", doneC, readM);
      end
      @(negedge Clk);
    end
    cpu_access(1, 0, 16'h0005, 16'h0, 0);
    n_checks++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_refill: miss=%0d hit=%0d expected 1 0", miss_count, hit_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a, d;
      bit          r, w;
      a = 16'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
      d = 16'($urandom);
      w = ($urandom_range(0, 2) == 0);
      r = !w || ($urandom_range(0, 3) == 0);
      cpu_access(r, w, a, d, $urandom_range(0, 3));
    end
  endtask

  initial begin
    mem[16'h0004] = 16'hAAAA;
    mem[16'h0005] = 16'hBBBB;
    mem[16'h0006] = 16'hCCCC;
    mem[16'h0007] = 16'hDDDD;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_priority();
    test_idle_ack();
    test_reset_during_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
